// File: rtl/cpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types for the CPU data-bus transfer controller.
//   BUS_DATA_W / BUS_IDX_W : widths that the command struct is built on
//   bus_xfer_state_e       : controller FSM states
//   bus_cmd_t              : one captured transfer command
//   idx_width()            : max(1, $clog2(n)), usable in parameter context
// -----------------------------------------------------------------------------
package cpu_bus_pkg;

    localparam int BUS_DATA_W = 8;
    localparam int BUS_IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WRITE = 2'd2
    } bus_xfer_state_e;

    typedef struct packed {
        logic [BUS_IDX_W-1:0]  src;
        logic [BUS_IDX_W-1:0]  dst;
        logic                  imm_sel;
        logic [BUS_DATA_W-1:0] imm;
    } bus_cmd_t;

    // A one-entry index space still needs a one-bit index signal.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_src_mux.sv
// -----------------------------------------------------------------------------
// bus_src_mux
// Combinational source select for the shared bus.
//   en       : drive enable; output is 0 when low
//   imm_sel  : 1 = take imm, 0 = take register slice src
//   imm      : immediate value
//   src      : register index
//   src_bus  : flattened register outputs, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data     : selected value
// An out-of-range src yields 0 (the controller never enables it that way).
// -----------------------------------------------------------------------------
module bus_src_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int IDX_W      = 3
) (
    input  logic                         en,
    input  logic                         imm_sel,
    input  logic [DATA_WIDTH-1:0]        imm,
    input  logic [IDX_W-1:0]             src,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] src_bus,
    output logic [DATA_WIDTH-1:0]        data
);

    always_comb begin
        data = '0;
        if (en) begin
            if (imm_sel) begin
                data = imm;
            end else begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (src == IDX_W'(k)) data = src_bus[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_transfer_ctrl
// Initiator for the shared register data bus. Accepts a transfer command,
// drives the source value onto the bus for SETTLE_CYCLES, then pulses one
// destination write enable for a single cycle.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_cmd_valid/o_cmd_ready : command handshake
//   i_cmd_src/dst/imm_sel/imm : command fields
//   i_src_bus               : flattened register outputs
//   o_bus                   : shared bus value (0 when idle)
//   o_we                    : one-hot destination write enable
//   o_busy                  : DRIVE or WRITE in progress
//   o_done / o_err          : one-cycle completion / rejection pulses
// The command struct comes from cpu_bus_pkg, so DATA_WIDTH and IDX_W must
// equal BUS_DATA_W and BUS_IDX_W.
// -----------------------------------------------------------------------------
module bus_transfer_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = BUS_DATA_W,
    parameter int NUM_REGS      = 8,
    parameter int SETTLE_CYCLES = 1,
    localparam int IDX_W        = idx_width(NUM_REGS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_cmd_valid,
    output logic                           o_cmd_ready,
    input  logic [IDX_W-1:0]               i_cmd_src,
    input  logic [IDX_W-1:0]               i_cmd_dst,
    input  logic                           i_cmd_imm_sel,
    input  logic [DATA_WIDTH-1:0]          i_cmd_imm,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_src_bus,
    output logic [DATA_WIDTH-1:0]          o_bus,
    output logic [NUM_REGS-1:0]            o_we,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err
);

    localparam int CNT_W = idx_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    bus_xfer_state_e state_q, state_d;
    bus_cmd_t        cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            cmd_bad;

    // Immediate commands never look at src, so its range only matters for
    // register-sourced transfers.
    assign cmd_bad = (32'(i_cmd_dst) >= NUM_REGS) ||
                     (!i_cmd_imm_sel && (32'(i_cmd_src) >= NUM_REGS));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    cmd_d.src     = i_cmd_src;
                    cmd_d.dst     = i_cmd_dst;
                    cmd_d.imm_sel = i_cmd_imm_sel;
                    cmd_d.imm     = i_cmd_imm;
                    if (cmd_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = DRIVE;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) state_d = WRITE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WRITE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus follows the live source slice through DRIVE and WRITE, so the
    // destination captures whatever is present at the WRITE-ending edge.
    bus_src_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_mux (
        .en      (state_q != IDLE),
        .imm_sel (cmd_q.imm_sel),
        .imm     (cmd_q.imm),
        .src     (cmd_q.src),
        .src_bus (i_src_bus),
        .data    (o_bus)
    );

    always_comb begin
        o_we = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            o_we[k] = (state_q == WRITE) && (cmd_q.dst == IDX_W'(k));
        end
    end

    assign o_cmd_ready = (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
module tb_bus_transfer_ctrl;

    logic        gclk = 1'b0;
    logic        grst_n = 1'b0;
    logic [2:0]  c_src = '0, c_dst = '0;
    logic        c_isel = 1'b0;
    logic [7:0]  c_imm = '0;

    logic        v1 = 1'b0, v3 = 1'b0, v6 = 1'b0;
    logic [63:0] src8 = '0;
    logic [47:0] src6 = '0;

    logic        r1, r3, r6, b1, b3, b6, d1, d3, d6, e1, e3, e6;
    logic [7:0]  bus1, bus3, bus6, we1, we3;
    logic [5:0]  we6;

    int n_chk = 0, n_err = 0;

    always #5 gclk = ~gclk;

    bus_transfer_ctrl #(.DATA_WIDTH(8), .NUM_REGS(8), .SETTLE_CYCLES(1)) u_s1 (
        .i_clk(gclk), .i_rst_n(grst_n), .i_cmd_valid(v1), .o_cmd_ready(r1),
        .i_cmd_src(c_src), .i_cmd_dst(c_dst), .i_cmd_imm_sel(c_isel), .i_cmd_imm(c_imm),
        .i_src_bus(src8), .o_bus(bus1), .o_we(we1), .o_busy(b1), .o_done(d1), .o_err(e1));

    bus_transfer_ctrl #(.DATA_WIDTH(8), .NUM_REGS(8), .SETTLE_CYCLES(3)) u_s3 (
        .i_clk(gclk), .i_rst_n(grst_n), .i_cmd_valid(v3), .o_cmd_ready(r3),
        .i_cmd_src(c_src), .i_cmd_dst(c_dst), .i_cmd_imm_sel(c_isel), .i_cmd_imm(c_imm),
        .i_src_bus(src8), .o_bus(bus3), .o_we(we3), .o_busy(b3), .o_done(d3), .o_err(e3));

    bus_transfer_ctrl #(.DATA_WIDTH(8), .NUM_REGS(6), .SETTLE_CYCLES(1)) u_n6 (
        .i_clk(gclk), .i_rst_n(grst_n), .i_cmd_valid(v6), .o_cmd_ready(r6),
        .i_cmd_src(c_src), .i_cmd_dst(c_dst), .i_cmd_imm_sel(c_isel), .i_cmd_imm(c_imm),
        .i_src_bus(src6), .o_bus(bus6), .o_we(we6), .o_busy(b6), .o_done(d6), .o_err(e6));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge gclk);
        #2;
    endtask

    task automatic cmd(input logic [2:0] s, input logic [2:0] d, input logic isel, input logic [7:0] imm);
        c_src = s; c_dst = d; c_isel = isel; c_imm = imm;
    endtask

    initial begin
        // ---- reset with valid held high: nothing accepted
        v1 = 1'b1; v3 = 1'b1; v6 = 1'b1;
        cmd(3'd2, 3'd5, 1'b0, 8'h00);
        src8[2*8 +: 8] = 8'hA5;
        step(); step();
        chk("rst_bus",   bus1, 8'h00);
        chk("rst_we",    we1,  8'h00);
        chk("rst_busy",  b1,   1'b0);
        chk("rst_done",  d1,   1'b0);
        chk("rst_err",   e1,   1'b0);
        chk("rst_ready", r1,   1'b1);
        chk("rst_busy3", b3,   1'b0);
        chk("rst_busy6", b6,   1'b0);
        v1 = 1'b0; v3 = 1'b0; v6 = 1'b0;
        grst_n = 1'b1;
        step();
        chk("post_rst_busy", b1, 1'b0);

        // ---- register transfer 2->5, SETTLE=1
        v1 = 1'b1;
        step();                                  // E0 accepts
        v1 = 1'b0;
        chk("r2r_drv_bus",  bus1, 8'hA5);
        chk("r2r_drv_we",   we1,  8'h00);
        chk("r2r_drv_busy", b1,   1'b1);
        chk("r2r_drv_rdy",  r1,   1'b0);
        step();
        chk("r2r_wr_we",  we1,  8'h20);
        chk("r2r_wr_bus", bus1, 8'hA5);
        step();
        chk("r2r_done",     d1,   1'b1);
        chk("r2r_done_err", e1,   1'b0);
        chk("r2r_done_we",  we1,  8'h00);
        chk("r2r_done_bus", bus1, 8'h00);
        chk("r2r_done_rdy", r1,   1'b1);
        step();
        chk("r2r_done_clr", d1,   1'b0);

        // ---- immediate 0x3C -> reg0, SETTLE=3
        cmd(3'd7, 3'd0, 1'b1, 8'h3C);
        v3 = 1'b1;
        step();
        v3 = 1'b0;
        cmd(3'd1, 3'd4, 1'b0, 8'hFF);            // ignored outside handshake
        for (int i = 0; i < 3; i++) begin
            chk("imm_drv_bus", bus3, 8'h3C);
            chk("imm_drv_we",  we3,  8'h00);
            chk("imm_drv_dn",  d3,   1'b0);
            step();
        end
        chk("imm_wr_we",  we3,  8'h01);
        chk("imm_wr_bus", bus3, 8'h3C);
        step();
        chk("imm_done",    d3,  1'b1);       // 5th cycle after accept edge
        chk("imm_done_we", we3, 8'h00);

        // ---- back-to-back (1->3) then (3->6), valid held high
        src8[1*8 +: 8] = 8'h11;
        src8[3*8 +: 8] = 8'h33;
        cmd(3'd1, 3'd3, 1'b0, 8'h00);
        v1 = 1'b1;
        step();                                  // first accepted
        chk("b2b_a_bus", bus1, 8'h11);
        cmd(3'd3, 3'd6, 1'b0, 8'h00);
        step();
        chk("b2b_a_we",  we1,  8'h08);
        step();
        chk("b2b_a_done", d1, 1'b1);
        chk("b2b_a_rdy",  r1, 1'b1);
        step();                                  // second accepted in done cycle
        v1 = 1'b0;
        chk("b2b_b_bus",  bus1, 8'h33);
        chk("b2b_b_busy", b1,   1'b1);
        src8[3*8 +: 8] = 8'h44;                  // source moves during DRIVE
        #1;
        chk("b2b_b_follow", bus1, 8'h44);
        step();
        chk("b2b_b_we",  we1,  8'h40);
        chk("b2b_b_wbus", bus1, 8'h44);
        step();
        chk("b2b_b_done", d1, 1'b1);
        step();

        // ---- NUM_REGS=6: illegal dst, then illegal src
        cmd(3'd0, 3'd7, 1'b0, 8'h00);
        v6 = 1'b1;
        step();
        cmd(3'd6, 3'd1, 1'b0, 8'h00);
        chk("bad_dst_done", d6,  1'b1);
        chk("bad_dst_err",  e6,  1'b1);
        chk("bad_dst_we",   we6, 6'h00);
        chk("bad_dst_busy", b6,  1'b0);
        step();
        v6 = 1'b0;
        chk("bad_src_done", d6,  1'b1);
        chk("bad_src_err",  e6,  1'b1);
        chk("bad_src_busy", b6,  1'b0);
        chk("bad_src_we",   we6, 6'h00);
        step();
        chk("bad_clr_done", d6, 1'b0);
        chk("bad_clr_err",  e6, 1'b0);
        // out-of-range src is fine with an immediate; dst=5 is the top register
        cmd(3'd7, 3'd5, 1'b1, 8'h5A);
        v6 = 1'b1;
        step();
        v6 = 1'b0;
        chk("n6_imm_busy", b6,   1'b1);
        chk("n6_imm_bus",  bus6, 8'h5A);
        step();
        chk("n6_imm_we",   we6,  6'h20);
        step();
        chk("n6_imm_done", d6, 1'b1);
        chk("n6_imm_err",  e6, 1'b0);
        step();

        // ---- reset asserted during DRIVE
        cmd(3'd0, 3'd2, 1'b1, 8'hC3);
        v3 = 1'b1;
        step();
        v3 = 1'b0;
        step();
        chk("ab_pre_busy", b3, 1'b1);
        grst_n = 1'b0;
        #1;
        chk("ab_bus",  bus3, 8'h00);
        chk("ab_we",   we3,  8'h00);
        chk("ab_busy", b3,   1'b0);
        chk("ab_rdy",  r3,   1'b1);
        step(); step();
        chk("ab_hold_we", we3, 8'h00);
        grst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ab_post_we",   we3, 8'h00);
            chk("ab_post_done", d3,  1'b0);
            chk("ab_post_rdy",  r3,  1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
